dac_channel_sequencer: RTL

- Multi-channel successor to the single-channel DAC mode mux. Sits between the per-channel RFDC_DDS generators, direct-sample AXIS writers and the RFDC DAC AXIS inputs.
- Each of NUM_CH channels independently selects DDS, DIRECT (buffered sample FIFO), HOLD or ZERO output.
- Mode changes are timestamped against the TimeController counter and applied cycle-exactly.

---
 rtl/dac_channel_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dac_channel_sequencer.sv
// Per-channel DAC source selector: DDS, buffered direct samples, hold or zero,
// with mode changes scheduled against the global time counter.
module dac_channel_sequencer #(
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              counter,
  input  logic                     mode_wr,
  input  logic [CH_W-1:0]          mode_ch,
  input  logic [1:0]               mode_val,
  input  logic [63:0]              mode_time,
  input  logic [NUM_CH*DATA_W-1:0] dds_tdata,
  input  logic [NUM_CH-1:0]        dds_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [NUM_CH-1:0]        fifo_flush,
  output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]        m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [NUM_CH*2-1:0]      cur_mode,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        underflow_err,
  output logic [NUM_CH-1:0]        late_err,
  output logic [NUM_CH-1:0]        overwrite_err,
  input  logic                     err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] MODE_DDS    = 2'd0;
  localparam logic [1:0] MODE_DIRECT = 2'd1;
  localparam logic [1:0] MODE_HOLD   = 2'd2;
  localparam logic [1:0] MODE_ZERO   = 2'd3;

  // Handshakes: a beat transfers on a clock edge where valid and ready are both
  // high; valid never waits on ready, and the output side advances only while
  // the shared m_axis_tready is high.
  logic valid_q;

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= 1'b1;
  end

  assign m_axis_tvalid = {NUM_CH{valid_q}};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [1:0]        mode_q, pend_mode, eff_mode;
    logic              pend_q;
    logic [63:0]       pend_time;
    logic [DATA_W-1:0] tdata_q;
    logic              uf_q, late_q, ow_q;
    logic              empty, full, ready, push, pop, apply, wr_hit;
    logic              uf_set, late_set, ow_set;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready = !reset && !full;
    assign push  = s_axis_tvalid[ch] && ready && !fifo_flush[ch];

    // A due pending request takes over the output decision in its apply cycle.
    assign apply    = pend_q && (counter >= pend_time);
    assign eff_mode = apply ? pend_mode : mode_q;
    assign wr_hit   = mode_wr && (mode_ch == CH_W'(ch));

    assign pop      = m_axis_tready && (eff_mode == MODE_DIRECT) && !empty;
    assign uf_set   = m_axis_tready && (eff_mode == MODE_DIRECT) && empty;
    assign late_set = wr_hit && (mode_time < counter);
    assign ow_set   = wr_hit && pend_q && !apply;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata[ch*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mode_q    <= MODE_DDS;
        pend_q    <= 1'b0;
        pend_mode <= MODE_DDS;
        pend_time <= '0;
        tdata_q   <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        uf_q      <= 1'b0;
        late_q    <= 1'b0;
        ow_q      <= 1'b0;
      end else begin
        mode_q <= eff_mode;
        if (wr_hit) begin
          pend_q    <= 1'b1;
          pend_mode <= mode_val;
          pend_time <= mode_time;
        end else if (apply) begin
          pend_q <= 1'b0;
        end

        if (m_axis_tready) begin
          case (eff_mode)
            MODE_DDS:    if (dds_tvalid[ch]) tdata_q <= dds_tdata[ch*DATA_W +: DATA_W];
            MODE_DIRECT: tdata_q <= empty ? '0 : mem[rd_ptr[AW-1:0]];
            MODE_ZERO:   tdata_q <= '0;
            default:     tdata_q <= tdata_q;
          endcase
        end

        if (fifo_flush[ch]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
          if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end

        uf_q   <= (uf_q   && !err_clear) || uf_set;
        late_q <= (late_q && !err_clear) || late_set;
        ow_q   <= (ow_q   && !err_clear) || ow_set;
      end
    end

    assign s_axis_tready[ch]                 = ready;
    assign m_axis_tdata[ch*DATA_W +: DATA_W] = tdata_q;
    assign cur_mode[2*ch +: 2]               = mode_q;
    assign pending[ch]                       = pend_q;
    assign underflow_err[ch]                 = uf_q;
    assign late_err[ch]                      = late_q;
    assign overwrite_err[ch]                 = ow_q;
  end

endmodule
